alu_op_sequencer: RTL and testbench

//  Initiator for the ALU command interface: accepts one operation (A, B, opcode) on a

---
 rtl/alu_op_sequencer.sv | 80 ++++++++
 tb/tb_alu_op_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready command in, phased ALU drive (setup/enable/wait), captured result out on valid/ready response
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int OP_W = 3,
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OP_W-1:0]  cmd_op,
  output logic             alu_enable,
  output logic [WIDTH-1:0] alu_data_a,
  output logic [WIDTH-1:0] alu_data_b,
  output logic [OP_W-1:0]  alu_opcode,
  input  logic [WIDTH-1:0] alu_results,
  input  logic             alu_cf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cf,
  output logic [OP_W-1:0]  rsp_op,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  localparam int LW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EXEC, S_WAIT, S_RESP} state_t;
  state_t state, state_nxt;
  logic [LW-1:0] lat_cnt;
  logic lat_done;
  assign lat_done = (lat_cnt == '0);
  assign cmd_ready = (state == S_IDLE);
  assign alu_enable = (state == S_EXEC);
  assign busy = (state != S_IDLE);
  always_comb begin
    state_nxt = (state == S_IDLE)  ? (cmd_valid ? S_SETUP : S_IDLE) :
                (state == S_SETUP) ? S_EXEC :
                (state == S_EXEC)  ? S_WAIT :
                (state == S_WAIT)  ? (lat_done ? S_RESP : S_WAIT) :
                (state == S_RESP)  ? (rsp_ready ? S_IDLE : S_RESP) : S_IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_data_a <= '0;
      alu_data_b <= '0;
      alu_opcode <= '0;
      lat_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_cf <= 1'b0;
      rsp_op <= '0;
      op_count <= '0;
    end else begin
      if (state == S_IDLE && cmd_valid) begin
        alu_data_a <= cmd_a;
        alu_data_b <= cmd_b;
        alu_opcode <= cmd_op;
      end
      if (state == S_EXEC) lat_cnt <= LW'(ALU_LATENCY - 1);
      else if (state == S_WAIT) lat_cnt <= lat_cnt - 1'b1;
      if (state == S_WAIT && lat_done) begin
        rsp_result <= alu_results;
        rsp_cf <= alu_cf;
        rsp_op <= alu_opcode;
        rsp_valid <= 1'b1;
      end
      if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count <= op_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench with a one-cycle-latency ALU model
module tb_alu_op_sequencer;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic alu_enable;
  logic [15:0] alu_data_a, alu_data_b;
  logic [2:0] alu_opcode;
  logic [15:0] alu_results = '0;
  logic alu_cf = 1'b0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic rsp_cf;
  logic [2:0] rsp_op;
  logic busy;
  logic [7:0] op_count;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_cnt = 0, en_last = 0, en_prev = 0;
  int acc_cnt = 0, acc_last = 0, acc_prev = 0;
  int hs_cnt = 0, hs_last = 0;
  logic [7:0] exp_cnt = '0;
  alu_op_sequencer #(.WIDTH(16), .OP_W(3), .ALU_LATENCY(1), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_enable(alu_enable), .alu_data_a(alu_data_a), .alu_data_b(alu_data_b), .alu_opcode(alu_opcode),
    .alu_results(alu_results), .alu_cf(alu_cf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cf(rsp_cf), .rsp_op(rsp_op),
    .busy(busy), .op_count(op_count)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    if (alu_enable) begin
      case (alu_opcode)
        3'b001: {alu_cf, alu_results} <= {1'b0, alu_data_a} + {1'b0, alu_data_b};
        3'b010: {alu_cf, alu_results} <= {1'b0, alu_data_a & alu_data_b};
        3'b011: {alu_cf, alu_results} <= {1'b0, alu_data_a | alu_data_b};
        default: {alu_cf, alu_results} <= '0;
      endcase
    end
  end
  always @(posedge CLK) begin
    cyc++;
    if (alu_enable) begin
      en_cnt++;
      en_prev = en_last;
      en_last = cyc;
    end
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      acc_prev = acc_last;
      acc_last = cyc;
    end
    if (rsp_valid && rsp_ready) begin
      hs_cnt++;
      hs_last = cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic [15:0] res, input logic cf);
    int e0 = en_cnt;
    chk("idle_rdy", cmd_ready, 1);
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    chk("setup_en", alu_enable, 0);
    chk("setup_a", alu_data_a, a);
    chk("setup_b", alu_data_b, b);
    chk("setup_busy", busy, 1);
    chk("setup_rdy", cmd_ready, 0);
    @(negedge CLK);
    chk("exec_en", alu_enable, 1);
    chk("exec_op", alu_opcode, op);
    @(negedge CLK);
    chk("wait_en", alu_enable, 0);
    chk("wait_vld", rsp_valid, 0);
    @(negedge CLK);
    chk("rsp_vld", rsp_valid, 1);
    chk("rsp_res", rsp_result, res);
    chk("rsp_cf", rsp_cf, cf);
    chk("rsp_op", rsp_op, op);
    @(negedge CLK);
    exp_cnt++;
    chk("done_vld", rsp_valid, 0);
    chk("done_cnt", op_count, exp_cnt);
    chk("done_rdy", cmd_ready, 1);
    chk("pulses", en_cnt - e0, 1);
  endtask
  initial begin
    int h0;
    repeat (3) @(negedge CLK);
    chk("rst_rdy", cmd_ready, 1);
    chk("rst_en", alu_enable, 0);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", op_count, 0);
    chk("rst_a", alu_data_a, 0);
    chk("rst_res", rsp_result, 0);
    RST = 1'b0;
    @(negedge CLK);
    do_op(16'h6464, 16'h4646, 3'b001, 16'hAAAA, 1'b0);
    do_op(16'hFFFF, 16'h0001, 3'b001, 16'h0000, 1'b1);
    cmd_a = 16'h6464;
    cmd_b = 16'h4646;
    cmd_op = 3'b010;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 10; k++) begin
      chk("hold_vld", rsp_valid, 1);
      chk("hold_res", rsp_result, 16'h4444);
      chk("hold_rdy", cmd_ready, 0);
      @(negedge CLK);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    exp_cnt++;
    chk("hold_done_vld", rsp_valid, 0);
    chk("hold_done_cnt", op_count, exp_cnt);
    h0 = acc_cnt;
    cmd_a = 16'h00F0;
    cmd_b = 16'h0F00;
    cmd_op = 3'b011;
    cmd_valid = 1'b1;
    for (int k = 0; k < 20 && acc_cnt - h0 < 2; k++) @(negedge CLK);
    cmd_valid = 1'b0;
    chk("b2b_acc", acc_cnt - h0, 2);
    chk("b2b_gap", acc_last - acc_prev, 5);
    chk("b2b_after_hs", acc_last - hs_last, 1);
    repeat (5) @(negedge CLK);
    exp_cnt += 2;
    chk("b2b_en_gap", en_last - en_prev, 5);
    chk("b2b_res", rsp_result, 16'h0FF0);
    chk("b2b_cnt", op_count, exp_cnt);
    chk("b2b_idle", cmd_ready, 1);
    h0 = hs_cnt;
    cmd_a = 16'h1234;
    cmd_b = 16'h1111;
    cmd_op = 3'b001;
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    exp_cnt = '0;
    chk("abort_vld", rsp_valid, 0);
    chk("abort_en", alu_enable, 0);
    chk("abort_cnt", op_count, 0);
    @(negedge CLK);
    chk("abort_rdy", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_vld2", rsp_valid, 0);
    chk("abort_no_rsp", hs_cnt - h0, 0);
    h0 = hs_cnt;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a, b;
      logic [16:0] s;
      a = 16'(i * 257);
      b = 16'(i * 3 + 16'hFE00);
      s = {1'b0, a} + {1'b0, b};
      do_op(a, b, 3'b001, s[15:0], s[16]);
      if (i == 254) chk("wrap_255", op_count, 255);
    end
    chk("wrap_0", op_count, 0);
    chk("wrap_rsps", hs_cnt - h0, 256);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
